sram_arb_ctrl: RTL
==================

Name: sram_arb_ctrl

Overview:
Two-port round-robin arbiter and access sequencer for the single-port bit-cell SRAM macro (DEPTH = 2**AW words of DW bits, combinational read).
- Serialises read/write requests from two requesters onto one memory port.
- Returns registered read data with a valid pulse.
- Optionally clears the whole array after reset.
- Sits between the memory macro and its two client blocks.

Parameters:
AW, 2, address width; memory depth = 2**AW
DW, 1, data word width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
req0  in  1  requester 0 access request, level, held until gnt0
we0  in  1  requester 0 write enable (1 = write, 0 = read), valid with req0
addr0  in  AW  requester 0 address
wdata0  in  DW  requester 0 write data
gnt0  out  1  one-cycle grant pulse to requester 0
rvalid0  out  1  one-cycle read-data-valid pulse to requester 0
rdata0  out  DW  requester 0 read data, holds until next read by requester 0
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as requester 0 ports, for requester 1
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, combinational from mem_addr
busy  out  1  controller not accepting requests

Behaviour:
- Reset: rst_n sampled low at a rising edge forces all outputs to 0 (busy = 1 if MEM_CLEAR_EN is defined), state to IDLE (CLEAR if MEM_CLEAR_EN), last_gnt to 1. Reset has priority over everything, including mid-access and mid-clear.
- IDLE:
  - At a rising edge where any req is high, pick the winner.
  - Latch the winner's we/addr/wdata into internal registers, set last_gnt = winner, go to ACCESS.
  - No req: stay in IDLE.
- Arbitration:
  - Single request wins.
  - Both requests: grant the requester not equal to last_gnt, so req0 wins the first contest after reset.
- ACCESS (exactly 1 cycle):
  - gnt_winner = 1, mem_en = 1.
  - mem_we / mem_addr / mem_wdata driven from the latched registers.
  - At the closing edge:
    - Read: rdata_winner <= mem_rdata and rvalid_winner = 1 for the following cycle.
    - Write: no rvalid.
  - Return to IDLE.
- Requester rule: deassert req, or present the next request, at the edge that ends the gnt cycle. IDLE samples req again one edge later.
- Throughput: max one access per 2 cycles. Read latency: req sampled at edge E, gnt during E..E+1, rvalid/rdata during E+1..E+2.
- Outside ACCESS/CLEAR: mem_en = 0, mem_we = 0, mem_addr and mem_wdata = 0.
- The non-granted requester's rdata is unchanged; its req stays pending and is honoured at the next IDLE edge.
- busy = 1 in ACCESS and CLEAR, 0 in IDLE.
- Register all outputs except the mem_* bus, which is decoded from state plus latched registers (glitch-free, no req→mem combinational path).

Optional Feature:
MEM_CLEAR_EN
- Defined:
  - Reset enters CLEAR with counter = 0.
  - Each cycle: mem_en = 1, mem_we = 1, mem_addr = counter, mem_wdata = 0; counter increments.
  - After address 2**AW-1, go to IDLE. CLEAR lasts 2**AW cycles.
  - busy = 1 throughout CLEAR; requests are held off, not dropped.
  - Reset asserted mid-clear restarts at address 0.
- Not defined:
  - No CLEAR state or counter logic; reset goes directly to IDLE.
  - busy is driven only by ACCESS.

Test Plan:
1. rst_n low 2 cycles with req0 = req1 = 1 -> all gnt/rvalid/rdata/mem_* = 0, busy = 0 (1 with MEM_CLEAR_EN), no grant until rst_n high.
2. Memory model preloaded {0,1,0,1}; req0 read addr0 = 1 sampled at edge E -> gnt0 = 1, mem_en = 1, mem_we = 0, mem_addr = 1 in E..E+1; rvalid0 = 1, rdata0 = 1 in E+1..E+2; gnt1 = rvalid1 = 0 throughout.
3. After reset, req0 (read addr 2) and req1 (read addr 3) rise together -> gnt0 first (rdata0 = 0), gnt1 two cycles later (rdata1 = 1).
4. req0 and req1 both held high continuously for 4 grants -> grant order 0,1,0,1, each gnt exactly one cycle, gnt cycles 2 cycles apart.
5. req1 write addr 2 data 1, then req1 read addr 2 -> write cycle: mem_we = 1, mem_wdata = 1, no rvalid1; read: rvalid1 = 1, rdata1 = 1; rdata0 unchanged.
6. MEM_CLEAR_EN, model {0,1,0,1}:
   - After reset: busy = 1 for 4 cycles, mem_we = 1, mem_addr = 0,1,2,3, mem_wdata = 0.
   - req0 read addr 1 raised during clear -> granted only after busy = 0, rdata0 = 0.
   - rst_n pulsed at addr 2 -> clear restarts at addr 0.

Source files
------------

// File: rtl/sram_arb_ctrl.sv
// Round-robin arbiter and sequencer for a single-port SRAM. A grant lasts one cycle and read data follows one cycle later.
// Requests stay pending until they are granted. Optional MEM_CLEAR_EN zeroes the whole array after reset while busy holds requests off.
module sram_arb_ctrl #(
  parameter int AW = 2,
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef struct packed {
    logic          who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

`ifdef MEM_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CLEAR} state_t;
  localparam state_t RST_STATE = S_CLEAR;
  localparam logic   RST_BUSY  = 1'b1;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACCESS} state_t;
  localparam state_t RST_STATE = S_IDLE;
  localparam logic   RST_BUSY  = 1'b0;
`endif

  state_t state, nxt_state;
  acc_t   acc, nxt_acc;
  logic   last_gnt, nxt_last_gnt;
  logic   win;
  logic   grant_now;
  logic   rd_done;

`ifdef MEM_CLEAR_EN
  logic [AW-1:0] clr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      clr_cnt <= '0;
    else if (state == S_CLEAR)
      clr_cnt <= clr_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RST_STATE;
      acc      <= '0;
      last_gnt <= 1'b1;
    end else begin
      state    <= nxt_state;
      acc      <= nxt_acc;
      last_gnt <= nxt_last_gnt;
    end
  end

  always_comb begin
    nxt_state    = state;
    nxt_acc      = acc;
    nxt_last_gnt = last_gnt;
    win          = 1'b0;
    grant_now    = 1'b0;
    rd_done      = 1'b0;
    // on a tie, the requester that was not granted last time wins
    if (req0 && req1)
      win = ~last_gnt;
    else
      win = req1;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_now    = 1'b1;
          nxt_state    = S_ACCESS;
          nxt_last_gnt = win;
          if (win)
            nxt_acc = '{who: 1'b1, we: we1, addr: addr1, wdata: wdata1};
          else
            nxt_acc = '{who: 1'b0, we: we0, addr: addr0, wdata: wdata0};
        end
      end
      S_ACCESS: begin
        rd_done   = ~acc.we;
        nxt_state = S_IDLE;
      end
`ifdef MEM_CLEAR_EN
      S_CLEAR: begin
        if (clr_cnt == {AW{1'b1}})
          nxt_state = S_IDLE;
      end
`endif
      default: nxt_state = S_IDLE;
    endcase
  end

  // memory bus depends only on registered state, never on the req inputs
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = acc.we;
        mem_addr  = acc.addr;
        mem_wdata = acc.wdata;
      end
`ifdef MEM_CLEAR_EN
      // held quiet while reset is still asserted so the macro sees no strobe during reset
      S_CLEAR: begin
        mem_en   = rst_n;
        mem_we   = rst_n;
        mem_addr = rst_n ? clr_cnt : '0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      busy    <= RST_BUSY;
    end else begin
      gnt0    <= grant_now & ~win;
      gnt1    <= grant_now & win;
      rvalid0 <= rd_done & ~acc.who;
      rvalid1 <= rd_done & acc.who;
      if (rd_done && !acc.who)
        rdata0 <= mem_rdata;
      if (rd_done && acc.who)
        rdata1 <= mem_rdata;
      busy    <= (nxt_state != S_IDLE);
    end
  end

endmodule
